// File: rtl/vreg_pkg.sv
// ---------------------------------------------------------------------------
// vreg_pkg
// Shared definitions for the regulator-side serial receiver:
//   - rx_state_e       : frame decoder FSM states
//   - CMD_OPERATION    : command code that switches the rail on/off
//   - CMD_VOUT         : command code that sets the rail voltage code
//   - DEFAULT_DEV_ADDR : 7-bit device address this receiver answers to
//   - ACK_BIT_IDX      : bit index of the 9th (acknowledge) clock of a byte
// ---------------------------------------------------------------------------
package vreg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CMD,
        ST_DATA,
        ST_WAIT_STOP,
        ST_IGNORE
    } rx_state_e;

    localparam logic [7:0] CMD_OPERATION    = 8'h01;
    localparam logic [7:0] CMD_VOUT         = 8'h21;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h60;
    localparam logic [3:0] ACK_BIT_IDX      = 4'd8;

endpackage

// File: rtl/vreg_line_sync.sv
// ---------------------------------------------------------------------------
// vreg_line_sync
// Brings one asynchronous serial line into the clk domain through a 2-flop
// synchronizer. When VREG_RX_GLITCH_FILTER_EN is defined, the synchronized
// value additionally passes through a stability filter: the output only
// follows the input once it has held a new level for FILTER_LEN consecutive
// cycles, so shorter pulses never reach the decoder.
//
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset (all stages reset to 1,
//                 the idle level of the bus)
//   line      in  raw asynchronous line
//   line_sync out synchronized (and optionally filtered) line
// ---------------------------------------------------------------------------
module vreg_line_sync #(
`ifdef VREG_RX_GLITCH_FILTER_EN
    parameter int FILTER_LEN = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic line_sync
);

    logic meta;
    logic stable;

    // Classic two-stage synchronizer; resets to the idle-high bus level so
    // leaving reset never looks like a line edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            stable <= 1'b1;
        end else begin
            meta   <= line;
            stable <= meta;
        end
    end

`ifdef VREG_RX_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] run_cnt;
    logic             filt;

    // Count how long the synchronized input has disagreed with the filtered
    // output; any return to the old level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            filt    <= 1'b1;
        end else if (stable == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
            run_cnt <= '0;
            filt    <= stable;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign line_sync = filt;
`else
    assign line_sync = stable;
`endif

endmodule

// File: rtl/vreg_serial_rx.sv
// ---------------------------------------------------------------------------
// vreg_serial_rx
// Regulator-side receiver for the two-wire voltage-regulator link. Decodes
// write-only frames {START, addr+W, command, data, STOP} addressed to
// DEV_ADDR and applies VOUT / OPERATION commands to the rail outputs.
// Optional glitch filter on both lines: define VREG_RX_GLITCH_FILTER_EN
// (adds the FILTER_LEN parameter).
//
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   vreg_scl     in  serial clock (asynchronous)
//   vreg_sda     in  serial data  (asynchronous)
//   vout_code    out committed rail voltage code
//   rail_enable  out rail on/off
//   update_pulse out one-cycle strobe on a committed write
//   frame_err    out one-cycle strobe on a malformed frame to this address
//   busy         out high while a frame is being decoded
//   err_count    out saturating count of frame_err strobes
// ---------------------------------------------------------------------------
module vreg_serial_rx
    import vreg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = DEFAULT_DEV_ADDR,
    parameter int          VOLT_WIDTH     = 4,
    parameter logic [VOLT_WIDTH-1:0] VOUT_RESET = VOLT_WIDTH'(4),
    parameter int          TIMEOUT_CYCLES = 4096
`ifdef VREG_RX_GLITCH_FILTER_EN
  , parameter int          FILTER_LEN     = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vreg_scl,
    input  logic                  vreg_sda,
    output logic [VOLT_WIDTH-1:0] vout_code,
    output logic                  rail_enable,
    output logic                  update_pulse,
    output logic                  frame_err,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, scl_edge, start_ev, stop_ev, ack_edge, timeout;

    rx_state_e       state, state_next;
    logic [3:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic [7:0]      cmd_reg;
    logic            addr_match;
    logic [TO_W-1:0] to_cnt;
    logic            err_next, commit_vout, commit_rail;

    vreg_line_sync
`ifdef VREG_RX_GLITCH_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_scl_sync (.clk(clk), .rst_n(rst_n), .line(vreg_scl), .line_sync(scl_s));

    vreg_line_sync
`ifdef VREG_RX_GLITCH_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_sda_sync (.clk(clk), .rst_n(rst_n), .line(vreg_sda), .line_sync(sda_s));

    // Previous synchronized sample of each line for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    // START/STOP need SCL high in both samples, so an SDA change that lands
    // together with an SCL edge is treated as ordinary data.
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign scl_edge = scl_rise | scl_fall;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
    assign ack_edge = scl_rise && (bit_cnt == ACK_BIT_IDX);
    assign timeout  = (state != ST_IDLE) && !scl_edge
                      && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign busy     = (state != ST_IDLE);

    // Next-state and event decoding. In WAIT_STOP the first SCL rise is the
    // setup clock of the STOP condition; only a following SCL fall proves
    // the master is clocking an extra byte.
    always_comb begin
        state_next  = state;
        err_next    = 1'b0;
        commit_vout = 1'b0;
        commit_rail = 1'b0;
        if (start_ev) begin
            state_next = ST_ADDR;
        end else if (timeout) begin
            state_next = ST_IDLE;
            err_next   = addr_match;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (stop_ev) begin
                        state_next = ST_IDLE;
                    end else if (ack_edge) begin
                        if (shift_reg[7:1] != DEV_ADDR) begin
                            state_next = ST_IGNORE;
                        end else if (shift_reg[0]) begin
                            state_next = ST_IGNORE;
                            err_next   = 1'b1;
                        end else begin
                            state_next = ST_CMD;
                        end
                    end
                end
                ST_CMD, ST_DATA: begin
                    if (stop_ev) begin
                        state_next = ST_IDLE;
                        err_next   = addr_match;
                    end else if (ack_edge) begin
                        state_next = (state == ST_CMD) ? ST_DATA : ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: begin
                    if (stop_ev) begin
                        state_next = ST_IDLE;
                        if (cmd_reg == CMD_VOUT) begin
                            if ((shift_reg >> VOLT_WIDTH) == 8'd0) begin
                                commit_vout = 1'b1;
                            end else begin
                                err_next = 1'b1;
                            end
                        end else if (cmd_reg == CMD_OPERATION) begin
                            commit_rail = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (scl_fall && (bit_cnt != 4'd0)) begin
                        state_next = ST_IGNORE;
                        err_next   = 1'b1;
                    end
                end
                ST_IGNORE: begin
                    if (stop_ev) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register plus the committed rail outputs and strobes; strobes
    // and commits land one cycle after the detecting event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            vout_code    <= VOUT_RESET;
            rail_enable  <= 1'b1;
            update_pulse <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= 8'd0;
            to_cnt       <= '0;
        end else begin
            state        <= state_next;
            update_pulse <= commit_vout | commit_rail;
            frame_err    <= err_next;
            if (commit_vout) begin
                vout_code <= shift_reg[VOLT_WIDTH-1:0];
            end
            if (commit_rail) begin
                rail_enable <= shift_reg[7];
            end
            if (err_next && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if ((state == ST_IDLE) || scl_edge) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Bit engine: shifts data bits MSB first, skips the ACK slot and latches
    // the command byte. The data byte stays in shift_reg until STOP, since
    // nothing shifts outside ADDR/CMD/DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= 4'd0;
            shift_reg  <= 8'd0;
            cmd_reg    <= 8'd0;
            addr_match <= 1'b0;
        end else if (start_ev || (state_next == ST_IDLE)) begin
            bit_cnt    <= 4'd0;
            addr_match <= 1'b0;
        end else if (state_next == ST_IGNORE) begin
            addr_match <= 1'b0;
        end else if (scl_rise) begin
            if (state == ST_WAIT_STOP) begin
                bit_cnt <= 4'd1;
            end else if (bit_cnt == ACK_BIT_IDX) begin
                bit_cnt <= 4'd0;
                if (state == ST_CMD) begin
                    cmd_reg <= shift_reg;
                end
                if (state_next == ST_CMD) begin
                    addr_match <= 1'b1;
                end
            end else begin
                shift_reg <= {shift_reg[6:0], sda_s};
                bit_cnt   <= bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vreg_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_vreg_serial_rx
// Bit-bangs frames onto vreg_scl/vreg_sda and compares the receiver against
// a frame-level model: each frame's expected effect (commit, error or
// nothing) is derived from its address, direction, command, data and how it
// was cut short. A per-cycle monitor checks the outputs never move without
// update_pulse and that err_count tracks the observed frame_err strobes.
// ---------------------------------------------------------------------------
module tb_vreg_serial_rx;

`ifdef VREG_RX_GLITCH_FILTER_EN
    localparam int PH = 10;
`else
    localparam int PH = 6;
`endif

    localparam int K_FULL    = 0;
    localparam int K_TRUNC   = 1;
    localparam int K_EXTRA   = 2;
    localparam int K_RESTART = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vreg_scl = 1'b1;
    logic       vreg_sda = 1'b1;
    logic [3:0] vout_code;
    logic       rail_enable;
    logic       update_pulse;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    int num_checks = 0;
    int num_errors = 0;

    // model state
    logic [3:0] m_vout;
    logic       m_rail;
    int         m_err;
    int         m_upd;
    int         m_ferr;

    // monitor state
    int         obs_upd;
    int         obs_ferr;
    logic [3:0] prev_vout;
    logic       prev_rail;

    vreg_serial_rx dut (
        .clk(clk), .rst_n(rst_n), .vreg_scl(vreg_scl), .vreg_sda(vreg_sda),
        .vout_code(vout_code), .rail_enable(rail_enable),
        .update_pulse(update_pulse), .frame_err(frame_err),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        num_checks++;
        if (actual != expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Per-cycle monitor: outputs only change alongside update_pulse, and the
    // error counter is the saturated number of frame_err strobes so far.
    always @(negedge clk) begin
        if (!rst_n) begin
            obs_upd   = 0;
            obs_ferr  = 0;
            prev_vout = 4'd4;
            prev_rail = 1'b1;
        end else begin
            if (update_pulse) obs_upd++;
            if (frame_err) obs_ferr++;
            if (!update_pulse) begin
                checkOutput("vout_stable", vout_code, prev_vout);
                checkOutput("rail_stable", rail_enable, prev_rail);
            end
            checkOutput("err_count_track", err_count, (obs_ferr > 255) ? 255 : obs_ferr);
            prev_vout = vout_code;
            prev_rail = rail_enable;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_err();
        m_ferr++;
        if (m_err < 255) m_err++;
    endtask

    task automatic model_full(input logic [6:0] addr, input logic rw,
                              input logic [7:0] cmd, input logic [7:0] data);
        if (addr == 7'h60) begin
            if (rw) begin
                model_err();
            end else if (cmd == 8'h21) begin
                if (data < 8'd16) begin
                    m_vout = data[3:0];
                    m_upd++;
                end else begin
                    model_err();
                end
            end else if (cmd == 8'h01) begin
                m_rail = data[7];
                m_upd++;
            end else begin
                model_err();
            end
        end
    endtask

    task automatic send_start();
        vreg_sda = 1'b1; vreg_scl = 1'b1; wait_clk(PH);
        vreg_sda = 1'b0; wait_clk(PH);
        vreg_scl = 1'b0; wait_clk(2);
    endtask

    task automatic send_rstart();
        vreg_sda = 1'b1; wait_clk(PH);
        vreg_scl = 1'b1; wait_clk(PH);
        vreg_sda = 1'b0; wait_clk(PH);
        vreg_scl = 1'b0; wait_clk(2);
    endtask

    task automatic send_stop();
        vreg_sda = 1'b0; wait_clk(PH);
        vreg_scl = 1'b1; wait_clk(PH);
        vreg_sda = 1'b1; wait_clk(PH);
    endtask

    task automatic send_bit(input logic b);
        vreg_sda = b; wait_clk(PH);
        vreg_scl = 1'b1; wait_clk(PH);
        vreg_scl = 1'b0; wait_clk(2);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_bit(b[7-i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
        send_bit(1'($urandom_range(0, 1)));
    endtask

    // Drives one frame of the given kind and updates the model with its
    // expected outcome. k = bits sent before a truncation/restart.
    task automatic applyStimulus(input logic [6:0] addr, input logic rw,
                                 input logic [7:0] cmd, input logic [7:0] data,
                                 input int kind, input int tbyte, input int k);
        send_start();
        if (kind == K_TRUNC && tbyte == 0) begin
            send_bits({addr, rw}, k);
            send_stop();
        end else begin
            send_byte({addr, rw});
            checkOutput("busy_mid_frame", busy, 1);
            if (kind == K_RESTART) begin
                send_bits(cmd, k);
                send_rstart();
                if (addr == 7'h60 && rw) model_err();
                send_byte({addr, rw});
            end
            if (kind == K_TRUNC && tbyte == 1) begin
                send_bits(cmd, k);
                send_stop();
                if (addr == 7'h60) model_err();
            end else begin
                send_byte(cmd);
                if (kind == K_TRUNC) begin
                    send_bits(data, k);
                    send_stop();
                    if (addr == 7'h60) model_err();
                end else begin
                    send_byte(data);
                    if (kind == K_EXTRA) begin
                        send_byte(8'($urandom));
                        send_stop();
                        if (addr == 7'h60) model_err();
                    end else begin
                        send_stop();
                        model_full(addr, rw, cmd, data);
                    end
                end
            end
        end
        wait_clk(12);
    endtask

    task automatic check_model();
        checkOutput("vout_code", vout_code, m_vout);
        checkOutput("rail_enable", rail_enable, m_rail);
        checkOutput("err_count", err_count, m_err);
        checkOutput("update_pulses", obs_upd, m_upd);
        checkOutput("frame_err_pulses", obs_ferr, m_ferr);
        checkOutput("busy_idle", busy, 0);
    endtask

    task automatic model_reset();
        m_vout = 4'd4;
        m_rail = 1'b1;
        m_err  = 0;
        m_upd  = 0;
        m_ferr = 0;
    endtask

    initial begin
        logic [6:0] r_addr;
        logic       r_rw;
        logic [7:0] r_cmd;
        logic [7:0] r_data;
        int         sel;

        model_reset();
        $display("[TB] reset");
        wait_clk(5);
        checkOutput("rst_vout", vout_code, 4);
        checkOutput("rst_rail", rail_enable, 1);
        checkOutput("rst_update", update_pulse, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        wait_clk(5);

        $display("[TB] directed frames");
        applyStimulus(7'h60, 1'b0, 8'h21, 8'h06, K_FULL, 0, 0);
        check_model();
        checkOutput("lit_vout_6", vout_code, 6);
        checkOutput("lit_upd_1", obs_upd, 1);
        checkOutput("lit_err_0", err_count, 0);

        applyStimulus(7'h61, 1'b0, 8'h21, 8'h03, K_FULL, 0, 0);
        check_model();
        checkOutput("lit_vout_other_addr", vout_code, 6);
        checkOutput("lit_no_err_other_addr", obs_ferr, 0);

        applyStimulus(7'h60, 1'b0, 8'h01, 8'h00, K_FULL, 0, 0);
        check_model();
        checkOutput("lit_rail_off", rail_enable, 0);
        applyStimulus(7'h60, 1'b0, 8'h01, 8'h80, K_FULL, 0, 0);
        check_model();
        checkOutput("lit_rail_on", rail_enable, 1);
        checkOutput("lit_upd_3", obs_upd, 3);

        applyStimulus(7'h60, 1'b0, 8'h21, 8'h1F, K_FULL, 0, 0);
        check_model();
        checkOutput("lit_vout_kept", vout_code, 6);
        checkOutput("lit_err_1", err_count, 1);
        applyStimulus(7'h60, 1'b0, 8'h55, 8'h00, K_FULL, 0, 0);
        check_model();
        checkOutput("lit_err_2", err_count, 2);

        applyStimulus(7'h60, 1'b0, 8'h21, 8'h05, K_TRUNC, 2, 4);
        check_model();
        checkOutput("lit_err_3_partial", err_count, 3);
        checkOutput("lit_vout_partial", vout_code, 6);
        applyStimulus(7'h60, 1'b0, 8'h21, 8'h02, K_RESTART, 0, 3);
        check_model();
        checkOutput("lit_vout_2", vout_code, 2);

        $display("[TB] timeout");
        send_start();
        send_byte({7'h60, 1'b0});
        wait_clk(4000);
        checkOutput("busy_before_timeout", busy, 1);
        wait_clk(200);
        checkOutput("busy_after_timeout", busy, 0);
        model_err();
        vreg_sda = 1'b0; wait_clk(PH);
        vreg_scl = 1'b1; wait_clk(PH);
        vreg_sda = 1'b1; wait_clk(12);
        check_model();
        checkOutput("lit_err_4_timeout", err_count, 4);

        $display("[TB] reset mid-frame");
        send_start();
        send_byte({7'h60, 1'b0});
        send_bits(8'h21, 4);
        rst_n = 1'b0;
        wait_clk(1);
        checkOutput("midrst_vout", vout_code, 4);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_err_count", err_count, 0);
        vreg_scl = 1'b1;
        vreg_sda = 1'b1;
        model_reset();
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        applyStimulus(7'h60, 1'b0, 8'h21, 8'h07, K_FULL, 0, 0);
        check_model();
        checkOutput("lit_vout_7_after_reset", vout_code, 7);

`ifdef VREG_RX_GLITCH_FILTER_EN
        $display("[TB] glitch rejection");
        vreg_sda = 1'b0; wait_clk(1);
        vreg_sda = 1'b1; wait_clk(20);
        checkOutput("glitch_no_start", busy, 0);
        check_model();
`endif

        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            sel    = $urandom_range(0, 3);
            r_addr = (sel < 3) ? 7'h60 : 7'($urandom);
            r_rw   = ($urandom_range(0, 7) == 0);
            sel    = $urandom_range(0, 2);
            r_cmd  = (sel == 0) ? 8'h21 : (sel == 1) ? 8'h01 : 8'($urandom);
            r_data = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            applyStimulus(r_addr, r_rw, r_cmd, r_data, $urandom_range(0, 3),
                          $urandom_range(0, 2), $urandom_range(1, 7));
            check_model();
        end

        $display("[TB] error counter saturation");
        while (m_ferr < 257) begin
            applyStimulus(7'h60, 1'b1, 8'h00, 8'h00, K_TRUNC, 1, 1);
        end
        check_model();
        checkOutput("lit_err_saturated", err_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
